// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame width and default baud divisor.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int UART_DATA_BITS    = 8;
    localparam int UART_DEFAULT_BAUD = 125000000 / 115200;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous board inputs; reset value is a parameter.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_r;
    logic q_r;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= RESET_VAL;
            q_r    <= RESET_VAL;
        end else begin
            meta_r <= d;
            q_r    <= meta_r;
        end
    end

    assign q = q_r;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and a one-entry valid/ready output register.
// Optional UART_RX_ERROR_FLAGS_EN adds frame_error and overrun pulse outputs.
module uart_rx
    import uart_pkg::*;
#(
    parameter int BAUD_LENGTH_IN_CYCLES = UART_DEFAULT_BAUD,
    parameter int SAMPLE_OFFSET         = BAUD_LENGTH_IN_CYCLES / 2
) (
    input  logic                      sysclk,
    input  logic                      rst,
    input  logic                      UART_RX,
    output logic [UART_DATA_BITS-1:0] data_out,
    output logic                      data_out_valid,
    input  logic                      data_out_ready,
    output logic                      busy
`ifdef UART_RX_ERROR_FLAGS_EN
    ,
    output logic                      frame_error,
    output logic                      overrun
`endif
);

    localparam int CNT_W = $clog2(BAUD_LENGTH_IN_CYCLES) + 1;
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_OFFSET - 1);
    localparam logic [CNT_W-1:0] BAUD_LAST   = CNT_W'(BAUD_LENGTH_IN_CYCLES - 1);

    logic                      cur_s;
    logic                      prev_r;
    logic                      fall_s;
    uart_state_t               state_r;
    logic [CNT_W-1:0]          cnt_r;
    logic [3:0]                bit_idx_r;
    logic [UART_DATA_BITS-1:0] shift_r;
    logic [UART_DATA_BITS-1:0] data_out_r;
    logic                      data_out_valid_r;
    logic                      busy_r;
`ifdef UART_RX_ERROR_FLAGS_EN
    logic                      frame_error_r;
    logic                      overrun_r;
`endif

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk (sysclk),
        .rst (rst),
        .d   (UART_RX),
        .q   (cur_s)
    );

    // Previous synchronized line value for falling-edge detection
    always_ff @(posedge sysclk) begin
        if (rst) begin
            prev_r <= 1'b1;
        end else begin
            prev_r <= cur_s;
        end
    end

    assign fall_s = prev_r & ~cur_s;

    // Frame FSM, bit sampling and output holding register
    always_ff @(posedge sysclk) begin
        if (rst) begin
            state_r          <= IDLE;
            cnt_r            <= '0;
            bit_idx_r        <= 4'd0;
            shift_r          <= '0;
            data_out_r       <= '0;
            data_out_valid_r <= 1'b0;
            busy_r           <= 1'b0;
`ifdef UART_RX_ERROR_FLAGS_EN
            frame_error_r    <= 1'b0;
            overrun_r        <= 1'b0;
`endif
        end else begin
`ifdef UART_RX_ERROR_FLAGS_EN
            frame_error_r <= 1'b0;
            overrun_r     <= 1'b0;
`endif
            // A consumed byte clears valid unless a new byte is loaded below
            if (data_out_valid_r && data_out_ready) begin
                data_out_valid_r <= 1'b0;
            end

            case (state_r)
                IDLE: begin
                    if (fall_s) begin
                        cnt_r   <= '0;
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (cnt_r == SAMPLE_LAST) begin
                        cnt_r <= '0;
                        if (!cur_s) begin
                            bit_idx_r <= 4'd0;
                            state_r   <= DATA;
                        end else begin
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DATA: begin
                    if (cnt_r == BAUD_LAST) begin
                        cnt_r     <= '0;
                        shift_r   <= {cur_s, shift_r[UART_DATA_BITS-1:1]};
                        bit_idx_r <= bit_idx_r + 4'd1;
                        if (bit_idx_r == 4'(UART_DATA_BITS - 1)) begin
                            state_r <= STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                STOP: begin
                    if (cnt_r == BAUD_LAST) begin
                        cnt_r   <= '0;
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                        if (cur_s) begin
                            // Holding register free or being drained this cycle
                            if (!data_out_valid_r || data_out_ready) begin
                                data_out_r       <= shift_r;
                                data_out_valid_r <= 1'b1;
                            end
`ifdef UART_RX_ERROR_FLAGS_EN
                            else begin
                                overrun_r <= 1'b1;
                            end
`endif
                        end
`ifdef UART_RX_ERROR_FLAGS_EN
                        else begin
                            frame_error_r <= 1'b1;
                        end
`endif
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign data_out       = data_out_r;
    assign data_out_valid = data_out_valid_r;
    assign busy           = busy_r;
`ifdef UART_RX_ERROR_FLAGS_EN
    assign frame_error    = frame_error_r;
    assign overrun        = overrun_r;
`endif

endmodule
